// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter.
package sram_arb_pkg;
    import SramCfg::*;

    typedef enum logic {ARB_INIT, ARB_RUN} ArbState;

    // Arbiter issues at most one access per cycle with no read/write collision rule.
    localparam bit SRAM_CFG_OK = (CON_RW == UNDEF);
endpackage

// File: rtl/sram_cfg_pkg.sv
// Configuration of the SRAM wrapper this arbiter drives.
package SramCfg;
    typedef enum logic [1:0] {UNDEF, RD_FIRST, WR_FIRST} ConRw;
    localparam ConRw CON_RW = UNDEF;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap-around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);
    always_comb begin
        int  idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among NREQ rdy/ack requesters; clears the SRAM
// after reset and on i_clr, and returns read data one cycle after issue.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [NREQ-1:0]  i_req_rdy,
    output logic [NREQ-1:0]  o_req_ack,
    input  logic [NREQ-1:0]  i_req_we,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]  o_rd_dval,
    output logic [DW-1:0]    o_rd_data,
    input  logic             i_clr,
    output logic             o_busy,
    output logic             o_sram_ce,
    output logic             o_sram_we,
    output logic [AW-1:0]    o_sram_addr,
    output logic [DW-1:0]    o_sram_wdata,
    input  logic [DW-1:0]    i_sram_rdata
);
    localparam int IW = $clog2(NREQ);

    if (!SRAM_CFG_OK) begin : g_cfg_chk
        $error("sram_port_arbiter requires SramCfg::CON_RW == UNDEF");
    end

    ArbState          state;
    logic [AW-1:0]    cnt;
    logic [IW-1:0]    rr_ptr;
    logic [NREQ-1:0]  dval_q;
    logic             busy_q;
    logic             hold_we;
    logic [AW-1:0]    hold_addr;
    logic [DW-1:0]    hold_wdata;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_id;
    logic             xfer;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req    (i_req_rdy),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign o_req_ack = (state == ARB_RUN) ? gnt : '0;
    assign xfer      = |o_req_ack;
    assign o_rd_dval = dval_q;
    assign o_rd_data = i_sram_rdata;
    assign o_busy    = busy_q;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = i_req_we[i];
                sel_addr  = i_req_addr[i*AW +: AW];
                sel_wdata = i_req_wdata[i*DW +: DW];
            end
        end
    end

    // Idle cycles keep the bus steady so the macro sees no spurious toggling.
    always_comb begin
        o_sram_ce    = 1'b0;
        o_sram_we    = hold_we;
        o_sram_addr  = hold_addr;
        o_sram_wdata = hold_wdata;
        if (state == ARB_INIT) begin
            o_sram_ce    = 1'b1;
            o_sram_we    = 1'b1;
            o_sram_addr  = cnt;
            o_sram_wdata = '0;
        end else if (xfer) begin
            o_sram_ce    = 1'b1;
            o_sram_we    = sel_we;
            o_sram_addr  = sel_addr;
            o_sram_wdata = sel_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= ARB_INIT;
            cnt        <= '0;
            rr_ptr     <= '0;
            dval_q     <= '0;
            busy_q     <= 1'b1;
            hold_we    <= 1'b1;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            if (o_sram_ce) begin
                hold_we    <= o_sram_we;
                hold_addr  <= o_sram_addr;
                hold_wdata <= o_sram_wdata;
            end
            // A read issued alongside i_clr still returns during the first clear cycle.
            dval_q <= (xfer && !sel_we) ? gnt : '0;
            case (state)
                ARB_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= ARB_RUN;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end
                end
                default: begin
                    if (xfer)
                        rr_ptr <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
                    if (i_clr) begin
                        state  <= ARB_INIT;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM.
module tb_sram_port_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   rdy, ack, we, dval;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]     rd_data;
    logic              clr, busy;
    logic              sram_ce, sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata, sram_rdata;
    logic [DW-1:0]     mem [2**AW];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req_rdy    (rdy),
        .o_req_ack    (ack),
        .i_req_we     (we),
        .i_req_addr   (addr),
        .i_req_wdata  (wdata),
        .o_rd_dval    (dval),
        .o_rd_data    (rd_data),
        .i_clr        (clr),
        .o_busy       (busy),
        .o_sram_ce    (sram_ce),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic chk_clear_cycle(input int c);
        chk("clr_addr", 32'(sram_addr), 32'(c));
        chk("clr_ce_we", {30'd0, sram_ce, sram_we}, 32'd3);
        chk("clr_wdata", 32'(sram_wdata), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_ack", 32'(ack), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; rdy = '0; we = '0; addr = '0; wdata = '0; clr = 1'b0;

        // 1. reset values, then a full 16-word clear with a requester waiting
        cyc(); cyc(); smp();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dval", 32'(dval), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_sram", {sram_ce, sram_we, 10'd0, 4'(sram_addr), sram_wdata}, {2'b11, 30'd0});
        rstn = 1'b1;
        rdy  = 4'b0010;
        set_req(1, 1'b0, 4'd3, 16'h0);
        for (int c = 0; c < 16; c++) begin
            if (c != 0) begin cyc(); smp(); end
            chk_clear_cycle(c);
        end
        cyc(); smp();
        chk("post_clr_busy", 32'(busy), 32'd0);
        chk("first_ack", 32'(ack), 32'b0010);
        cyc(); rdy = '0; smp();
        chk("first_dval", 32'(dval), 32'b0010);
        chk("first_data", 32'(rd_data), 32'd0);

        // 2. write then read-back by requester 2
        cyc(); rdy = 4'b0100; set_req(2, 1'b1, 4'd5, 16'hBEEF); smp();
        chk("wr_ack", 32'(ack), 32'b0100);
        chk("wr_sram", {sram_ce, sram_we, 10'd0, 4'(sram_addr), sram_wdata}, {2'b11, 10'd0, 4'd5, 16'hBEEF});
        cyc(); set_req(2, 1'b0, 4'd5, 16'h0); smp();
        chk("rd_ack", 32'(ack), 32'b0100);
        cyc(); rdy = '0; smp();
        chk("rd_dval", 32'(dval), 32'b0100);
        chk("rd_data", 32'(rd_data), 32'hBEEF);
        chk("idle_ce", 32'(sram_ce), 32'd0);
        chk("idle_hold", 32'(sram_addr), 32'd5);

        // requester 3 alone moves rr_ptr back to 0
        cyc(); rdy = 4'b1000; set_req(3, 1'b0, 4'd0, 16'h0); smp();
        chk("p3_ack", 32'(ack), 32'b1000);

        // 3. fairness with all four requesters reading
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c == 0) begin
                rdy = 4'b1111;
                for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(8 + i), 16'h0);
            end
            smp();
            chk("fair_ack", 32'(ack), 32'(1 << (c % 4)));
            if (c > 0) chk("fair_dval", 32'(dval), 32'(1 << ((c - 1) % 4)));
        end
        cyc(); rdy = '0; smp();
        chk("fair_dval_last", 32'(dval), 32'b1000);

        // 4. skip and wrap: rr_ptr brought to 3 by requester 2 writing 0x1234 @7
        cyc(); rdy = 4'b0100; set_req(2, 1'b1, 4'd7, 16'h1234); smp();
        chk("w7_ack", 32'(ack), 32'b0100);
        cyc(); rdy = 4'b1010; set_req(1, 1'b0, 4'd1, 16'h0); set_req(3, 1'b0, 4'd2, 16'h0); smp();
        chk("wrap_ack3", 32'(ack), 32'b1000);
        cyc(); smp();
        chk("wrap_ack1", 32'(ack), 32'b0010);
        chk("wrap_dval3", 32'(dval), 32'b1000);
        cyc(); rdy = 4'b1111; for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'(i), 16'h0); smp();
        chk("ptr_is_2", 32'(ack), 32'b0100);
        chk("wrap_dval1", 32'(dval), 32'b0010);

        // 5. clear pulsed with a read of address 7 in flight
        cyc(); rdy = 4'b0001; set_req(0, 1'b0, 4'd7, 16'h0); clr = 1'b1; smp();
        chk("clr_rd_ack", 32'(ack), 32'b0001);
        cyc(); rdy = '0; clr = 1'b0; smp();
        chk("clr_rd_dval", 32'(dval), 32'b0001);
        chk("clr_rd_data", 32'(rd_data), 32'h1234);
        chk_clear_cycle(0);
        for (int c = 1; c < 16; c++) begin
            cyc(); smp();
            chk_clear_cycle(c);
        end
        cyc(); rdy = 4'b0001; smp();
        chk("clr2_busy", 32'(busy), 32'd0);
        chk("rd7_ack", 32'(ack), 32'b0001);
        cyc(); rdy = '0; smp();
        chk("rd7_dval", 32'(dval), 32'b0001);
        chk("rd7_zero", 32'(rd_data), 32'd0);

        // 6. reset asserted for one cycle at clear count 9
        cyc(); clr = 1'b1; smp();
        chk("clr3_ack", 32'(ack), 32'd0);
        cyc(); clr = 1'b0; smp();
        chk_clear_cycle(0);
        repeat (9) cyc();
        smp();
        chk("at_cnt9", 32'(sram_addr), 32'd9);
        rstn = 1'b0;
        cyc(); smp();
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_sram", {sram_ce, sram_we, 10'd0, 4'(sram_addr), sram_wdata}, {2'b11, 30'd0});
        chk("rst2_ack_dval", {24'd0, ack, dval}, 32'd0);
        rstn = 1'b1;
        for (int c = 1; c < 16; c++) begin
            cyc(); smp();
            chk_clear_cycle(c);
        end
        cyc(); smp();
        chk("rst2_done", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port SRAM macro among `NREQ` requesters that each present a `rdyack` command port, and returns read data to the issuing requester with a `dval` strobe. After reset, and on request, the block runs an SRAM clear sequence that zeroes every word before serving requesters. It sits between the accelerator's buffer clients and the SRAM wrapper configured through `SramCfg`, where `CON_RW` is `UNDEF` and at most one access is issued per cycle.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 10: SRAM address width; `DEPTH = 2**AW`.
- `DW`, 16: SRAM data width.

- `i_clk`  in  1  sole clock, rising edge.
- `i_rstn`  in  1  reset. Active-low, synchronous: sampled only at the `i_clk` rising edge.
- `i_req_rdy`  in  NREQ  per-requester command valid.
- `o_req_ack`  out  NREQ  per-requester command accept; a transfer occurs when `rdy && ack`.
- `i_req_we`  in  NREQ  1 = write, 0 = read.
- `i_req_addr`  in  NREQ×AW  command address.
- `i_req_wdata`  in  NREQ×DW  write data.
- `o_rd_dval`  out  NREQ  one-hot read-return strobe.
- `o_rd_data`  out  DW  read-return data, shared by all requesters.
- `i_clr`  in  1  one-cycle pulse that starts an SRAM clear.
- `o_busy`  out  1  high while clearing.
- `o_sram_ce`  out  1  SRAM chip enable.
- `o_sram_we`  out  1  SRAM write enable.
- `o_sram_addr`  out  AW  SRAM address.
- `o_sram_wdata`  out  DW  SRAM write data.
- `i_sram_rdata`  in  DW  SRAM read data, valid 1 cycle after a read is issued.

## Operation
- The FSM has two states, `INIT` and `RUN`. Reset enters `INIT` with the clear counter at 0.
- `INIT`:
  - Each cycle drives `ce=1`, `we=1`, `addr=cnt`, `wdata=0`.
  - The counter increments by 1 each cycle.
  - When `cnt==DEPTH-1` the write completes, and the next state is `RUN` with the counter cleared.
  - `o_req_ack` is held at 0 in this state.
  - `i_clr` is ignored in this state; the clear is not restarted.
- `RUN`:
  - The arbiter searches upward from `rr_ptr`, with wrap-around, for the first requester with `i_req_rdy=1`. That requester is the grant.
  - `o_req_ack` is the one-hot grant. It is 0 when no requester is ready.
  - The SRAM outputs follow the granted command combinationally: `ce=1` and `we`, `addr`, `wdata` come from the grant.
  - With no grant, `ce=0` and `we/addr/wdata` hold their last values.
  - On a transfer, `rr_ptr <= (grant+1) mod NREQ`. With no transfer, `rr_ptr` holds.
- `i_clr=1` in `RUN` finishes the current cycle's transfer normally, then enters `INIT` at the next edge.
- Read return: a read transfer registers `rd_id`. In the next cycle, `o_rd_dval[rd_id]=1` and `o_rd_data=i_sram_rdata`.
- Reads issued in the cycle before a clear begins still return their data.
- `o_rd_data` is don't-care when `o_rd_dval==0`.
- Requesters must hold `addr/we/wdata` stable while `rdy=1 && ack=0`. The block does not check this.

## Timing
- Values during reset and in the cycle after reset is released:
  - `o_req_ack=0`, `o_rd_dval=0`, `o_busy=1`.
  - `o_sram_ce=1`, `o_sram_we=1`, `o_sram_addr=0`, `o_sram_wdata=0`.
  - `rr_ptr=0`.
- `o_busy` is registered and equals `state==INIT`.
- A clear lasts exactly `DEPTH` cycles of `INIT`.
- The first requester `ack` can occur in the cycle after the last clear write.
- Command acceptance is combinational: `ack` appears in the same cycle as `rdy` when `rdy` is granted.
- Throughput is 1 command per cycle, aggregate across all requesters.
- Read latency is 1 cycle from the transfer to `o_rd_dval`.
- Back-to-back reads from different requesters produce consecutive `dval` pulses, each with the correct one-hot bit.
- A write followed by a read of the same address in the next cycle returns the new data, because the macro is single-port and accesses are serialized.
- `i_rstn` low mid-operation, including mid-clear or with a read in flight:
  - At the next edge, all registers return to their reset values.
  - Any pending `dval` is dropped.
  - The clear restarts from address 0.

## Structure
- Shared package `sram_arb_pkg`:
  - `typedef enum {ARB_INIT, ARB_RUN} ArbState`.
  - Imports `SramCfg`, and requires `CON_RW == UNDEF` via a static elaboration check.
- Sub-module `rr_pick`:
  - Combinational round-robin picker with parameter `N`.
  - Inputs: `req[N]` and `ptr[$clog2(N)]`.
  - Outputs: `gnt[N]` (one-hot) and `gnt_id`.
  - `rr_pick` is reused by other arbiters.
- All state uses a single `always_ff @(posedge i_clk)` with `if (!i_rstn)`, because reset is synchronous.

## Test plan
Bench parameters: `NREQ=4`, `AW=4`, `DW=16`.

1. Reset release:
   - Stimulus: release reset.
   - Response: 16 consecutive cycles of SRAM writes to addresses 0..15 with data 0, and `o_busy=1` throughout. `o_busy` falls in the 17th cycle. A `rdy` raised during the clear receives no `ack`.
2. Single requester:
   - Stimulus: requester 2 writes `0xBEEF` to address 5, then reads address 5 in the next cycle.
   - Response: `ack[2]` in both cycles. One cycle after the read, `o_rd_dval=4'b0100` and `o_rd_data=0xBEEF`.
3. Fairness:
   - Stimulus: all four requesters hold `rdy=1` with reads for 8 cycles, starting from `rr_ptr=0`.
   - Response: the grant order is 0,1,2,3,0,1,2,3, and the `dval` sequence matches, delayed by 1 cycle.
4. Skip and wrap:
   - Stimulus: `rr_ptr=3` with only requesters 1 and 3 ready.
   - Response: requester 3 is granted first, then requester 1, and `rr_ptr` ends at 2.
5. Clear mid-stream:
   - Stimulus: address 7 holds `0x1234`. Requester 0 reads address 7 in the same cycle that `i_clr` pulses.
   - Response: the read returns `0x1234` with `dval[0]`, the clear sequence follows, and a later read of address 7 returns 0.
6. Reset mid-clear:
   - Stimulus: drive `i_rstn=0` for 1 cycle at clear count 9.
   - Response: the clear restarts at address 0, runs a full 16 cycles, and all outputs take their reset values on the first edge with `i_rstn` low.
